// File: rtl/console_writer.sv
// console_writer: text-console front end for a VGA text-mode framebuffer.
//
// It takes a character byte stream over a valid/ready handshake and keeps a
// cursor (row, col). Printable bytes become framebuffer cell writes. Control
// codes move the cursor or start a clear sweep. The display wraps to the top
// row; it does not scroll.
//
// Optional feature: define CONSOLE_ATTR_EN to add the in_attr input. It is
// sampled with in_data and drives bit 8 of printable cell writes.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   in_data      character byte
//   in_valid     in_data is valid
//   in_attr      attribute bit for printable writes (CONSOLE_ATTR_EN only)
//   in_ready     a byte is accepted this cycle when in_valid is also high
//   bus_wraddr   cell address {1'b0, row[4:0], col[6:0]}
//   bus_wrdata   cell value {attr, char}
//   bus_wrvalid  write request
//   bus_wrready  framebuffer accepts the write
module console_writer #(
    parameter int COLS  = 80,   // must be <= 128
    parameter int ROWS  = 25,   // must be <= 32
    parameter int TAB_W = 8     // must be a power of two
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
`ifdef CONSOLE_ATTR_EN
    input  logic        in_attr,
`endif
    output logic        in_ready,
    output logic [12:0] bus_wraddr,
    output logic [8:0]  bus_wrdata,
    output logic        bus_wrvalid,
    input  logic        bus_wrready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUT,
        S_CLR_ROW,
        S_CLR_ALL
    } state_t;

    localparam logic [6:0] LP_COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] LP_ROW_LAST = 5'(ROWS - 1);
    localparam logic [6:0] LP_TAB_MASK = 7'(TAB_W - 1);
    localparam logic [8:0] LP_BLANK    = 9'h020;

    state_t      r_state;
    logic [4:0]  r_row;
    logic [6:0]  r_col;
    logic [4:0]  r_clr_row;   // next cell to issue in a clear sweep
    logic [6:0]  r_clr_col;
    logic        r_clr_last;  // final cell of the sweep has been issued
    logic        r_wrap;      // printable write is followed by a row clear
    logic        r_wrvalid;
    logic [12:0] r_wraddr;
    logic [8:0]  r_wrdata;
    logic        r_in_ready;

    logic        w_attr;
    logic        w_accept;
    logic        w_slot_free;
    logic        w_printable;
    logic        w_newline;
    logic [4:0]  w_row_next;
    logic [7:0]  w_tab_col;

`ifdef CONSOLE_ATTR_EN
    assign w_attr = in_attr;
`else
    assign w_attr = 1'b0;
`endif

    assign w_accept    = in_valid && r_in_ready;
    // A new write can be loaded when nothing is pending or the pending one completes now.
    assign w_slot_free = !r_wrvalid || bus_wrready;
    assign w_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign w_row_next  = (r_row == LP_ROW_LAST) ? 5'd0 : r_row + 5'd1;
    // Computed one bit wider so a tab past the last column cannot alias back to a small value.
    assign w_tab_col   = {1'b0, r_col & ~LP_TAB_MASK} + 8'(TAB_W);
    assign w_newline   = (in_data == 8'h0A) ||
                         ((in_data == 8'h09) && (w_tab_col >= 8'(COLS)));

    assign in_ready    = r_in_ready;
    assign bus_wraddr  = r_wraddr;
    assign bus_wrdata  = r_wrdata;
    assign bus_wrvalid = r_wrvalid;

    // NOTE: reset is sampled on the clock edge (synchronous). Every register, state included, sits under it.
    // NOTE: all state updates use non-blocking assignments, so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_CLR_ALL;
            r_row      <= 5'd0;
            r_col      <= 7'd0;
            r_clr_row  <= 5'd0;
            r_clr_col  <= 7'd0;
            r_clr_last <= 1'b0;
            r_wrap     <= 1'b0;
            r_wrvalid  <= 1'b0;
            r_wraddr   <= 13'd0;
            r_wrdata   <= 9'd0;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_wrvalid  <= 1'b1;
                            r_wraddr   <= {1'b0, r_row, r_col};
                            r_wrdata   <= {w_attr, in_data};
                            r_in_ready <= 1'b0;
                            r_state    <= S_PUT;
                            r_clr_col  <= 7'd0;
                            r_clr_last <= 1'b0;
                            if (r_col == LP_COL_LAST) begin
                                r_col     <= 7'd0;
                                r_row     <= w_row_next;
                                r_clr_row <= w_row_next;
                                r_wrap    <= 1'b1;
                            end else begin
                                r_col  <= r_col + 7'd1;
                                r_wrap <= 1'b0;
                            end
                        end else if (w_newline) begin
                            r_col      <= 7'd0;
                            r_row      <= w_row_next;
                            r_clr_row  <= w_row_next;
                            r_clr_col  <= 7'd0;
                            r_clr_last <= 1'b0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_CLR_ROW;
                        end else begin
                            case (in_data)
                                8'h0D: r_col <= 7'd0;
                                8'h08: if (r_col != 7'd0) r_col <= r_col - 7'd1;
                                8'h09: r_col <= w_tab_col[6:0];
                                8'h0C: begin
                                    r_clr_row  <= 5'd0;
                                    r_clr_col  <= 7'd0;
                                    r_clr_last <= 1'b0;
                                    r_in_ready <= 1'b0;
                                    r_state    <= S_CLR_ALL;
                                end
                                default: ;  // consumed and ignored
                            endcase
                        end
                    end
                end

                S_PUT: begin
                    if (r_wrvalid && bus_wrready) begin
                        r_wrvalid <= 1'b0;
                        if (r_wrap) begin
                            r_state <= S_CLR_ROW;
                        end else begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                S_CLR_ROW, S_CLR_ALL: begin
                    if (w_slot_free) begin
                        if (r_clr_last) begin
                            r_wrvalid  <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                            if (r_state == S_CLR_ALL) begin
                                r_row <= 5'd0;
                                r_col <= 7'd0;
                            end
                        end else begin
                            r_wrvalid <= 1'b1;
                            r_wraddr  <= {1'b0, r_clr_row, r_clr_col};
                            r_wrdata  <= LP_BLANK;
                            if (r_clr_col == LP_COL_LAST) begin
                                r_clr_col <= 7'd0;
                                if ((r_state == S_CLR_ROW) || (r_clr_row == LP_ROW_LAST))
                                    r_clr_last <= 1'b1;
                                else
                                    r_clr_row <= r_clr_row + 5'd1;
                            end else begin
                                r_clr_col <= r_clr_col + 7'd1;
                            end
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer. Expected cell writes are queued when
// stimulus is driven and popped by a monitor when the DUT completes a write.
module tb_console_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] bus_wraddr;
    logic [8:0]  bus_wrdata;
    logic        bus_wrvalid;
    logic        bus_wrready = 1'b0;
`ifdef CONSOLE_ATTR_EN
    logic        in_attr = 1'b0;
`endif

    int n_total = 0;
    int n_pass  = 0;
    logic [21:0] exp_q[$];

    console_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
`ifdef CONSOLE_ATTR_EN
        .in_attr     (in_attr),
`endif
        .in_ready    (in_ready),
        .bus_wraddr  (bus_wraddr),
        .bus_wrdata  (bus_wrdata),
        .bus_wrvalid (bus_wrvalid),
        .bus_wrready (bus_wrready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Write completes on the next rising edge; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus_wrvalid && bus_wrready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                assert (exp_q.size() != 0) n_pass++;
                else $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write",
                            bus_wraddr, bus_wrdata);
            end else begin
                logic [21:0] w;
                w = exp_q.pop_front();
                check("bus_write", 32'({bus_wraddr, bus_wrdata}), 32'(w));
            end
        end
    end

    task automatic push_exp(input logic [4:0] row, input logic [6:0] col, input logic [8:0] data);
        exp_q.push_back({1'b0, row, col, data});
    endtask

    task automatic push_clr_row(input logic [4:0] row);
        for (int c = 0; c < 80; c++) push_exp(row, 7'(c), 9'h020);
    endtask

    task automatic send(input logic [7:0] b);
        int cyc;
        cyc = 0;
        @(posedge clk);
        #1;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("accept_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        @(posedge clk);
        #1;
        while (!(exp_q.size() == 0 && in_ready === 1'b1) && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus_wrready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wrvalid", 32'(bus_wrvalid), 32'd0);
        check("rst_wraddr",  32'(bus_wraddr),  32'd0);
        check("rst_wrdata",  32'(bus_wrdata),  32'd0);
        check("rst_in_ready", 32'(in_ready),   32'd0);

        // Power-up clear: 2000 blanks, row-major, then in_ready the next cycle.
        for (int r = 0; r < 25; r++) push_clr_row(5'(r));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            int cyc;
            cyc = 0;
            @(posedge clk);
            #1;
            while (exp_q.size() != 0 && cyc < 2500) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check("clr_all_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("clr_all_in_ready", 32'(in_ready), 32'd1);
        check("clr_all_wrvalid_low", 32'(bus_wrvalid), 32'd0);

        // 'A' at (0,0): write the cycle after acceptance, ready again after completion.
        push_exp(5'd0, 7'd0, 9'h041);
        send(8'h41);
        @(negedge clk);
        check("put_valid_next_cycle", 32'(bus_wrvalid), 32'd1);
        check("put_addr", 32'(bus_wraddr), 32'h000);
        @(negedge clk);
        check("throughput_ready", 32'(in_ready), 32'd1);
        push_exp(5'd0, 7'd1, 9'h042);
        send(8'h42);
        wait_drain("drain_AB");

        // Back-pressure: held for 5 cycles, completes once.
        @(posedge clk);
        #1;
        bus_wrready = 1'b0;
        push_exp(5'd0, 7'd2, 9'h043);
        send(8'h43);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_wrvalid", 32'(bus_wrvalid), 32'd1);
            check("stall_addr",    32'(bus_wraddr),  32'h002);
            check("stall_data",    32'(bus_wrdata),  32'h043);
            check("stall_in_ready", 32'(in_ready),   32'd0);
        end
        @(posedge clk);
        #1;
        bus_wrready = 1'b1;
        wait_drain("drain_stall");

        // TAB from col 3 lands on col 8.
        send(8'h09);
        push_exp(5'd0, 7'd8, 9'h054);
        send(8'h54);
        wait_drain("drain_tab");

        // CR, BS at col 0, and BEL produce no writes; the next char lands at col 0.
        send(8'h0D);
        send(8'h08);
        send(8'h07);
        @(negedge clk);
        check("ctrl_no_write", 32'(bus_wrvalid), 32'd0);
        check("ctrl_in_ready", 32'(in_ready), 32'd1);
        push_exp(5'd0, 7'd0, 9'h079);
        send(8'h79);
        wait_drain("drain_bs");

        // 80 chars fill row 0; the wrap clears row 1 before the 81st char lands at (1,0).
        send(8'h0D);
        for (int i = 0; i < 80; i++) begin
            push_exp(5'd0, 7'(i), 9'(8'h61 + 8'(i % 26)));
            if (i == 79) push_clr_row(5'd1);
            send(8'h61 + 8'(i % 26));
        end
        push_exp(5'd1, 7'd0, 9'h051);
        send(8'h51);
        wait_drain("drain_wrap");

        // LF down to row 24, move to col 5, then LF wraps to row 0 and clears it.
        send(8'h0D);
        for (int r = 2; r < 25; r++) begin
            push_clr_row(5'(r));
            send(8'h0A);
        end
        for (int c = 0; c < 5; c++) begin
            push_exp(5'd24, 7'(c), 9'h020);
            send(8'h20);
        end
        push_clr_row(5'd0);
        send(8'h0A);
        push_exp(5'd0, 7'd0, 9'h078);
        send(8'h78);
        wait_drain("drain_lf_wrap");

        // Form feed clears the whole screen and homes the cursor.
        for (int r = 0; r < 25; r++) push_clr_row(5'(r));
        send(8'h0C);
        push_exp(5'd0, 7'd0, 9'h07A);
        send(8'h7A);
        wait_drain("drain_ff");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
